// File: rtl/fpu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fpu_pkg : shared types and constants for the FPU arbiter slice        |
// | rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
package fpu_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 7;
  localparam int MANT_W = 24;
  localparam int WORD_W = SIGN_W + EXP_W + MANT_W;

  localparam int STAT_EXACT     = 0;
  localparam int STAT_OVERFLOW  = 1;
  localparam int STAT_UNDERFLOW = 2;
  localparam int STAT_INEXACT   = 3;
  localparam int STAT_W         = STAT_INEXACT + 1;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [STAT_W-1:0] status_t;

  // Every defined status flag; undefined bits from the FPU never reach a requester.
  localparam status_t STAT_MASK = status_t'((1 << STAT_EXACT) | (1 << STAT_OVERFLOW) |
                                            (1 << STAT_UNDERFLOW) | (1 << STAT_INEXACT));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fpu_rr_arb2.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fpu_rr_arb2 : two-way round-robin grant, one-hot output               |
// | rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module fpu_rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (valid0_i && valid1_i) begin
      // Contention goes to whichever port was not served last.
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end else if (valid0_i) begin
      grant_o = 2'b01;
    end else if (valid1_i) begin
      grant_o = 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fpu_arbiter : shares one FPU between two requesters, one op in flight |
// | rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WORD_W-1:0] req0_a,
  input  logic [WORD_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WORD_W-1:0] req1_a,
  input  logic [WORD_W-1:0] req1_b,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WORD_W-1:0] rsp0_data,
  output logic [STAT_W-1:0] rsp0_status,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WORD_W-1:0] rsp1_data,
  output logic [STAT_W-1:0] rsp1_status,

  output logic [WORD_W-1:0] fpu_a,
  output logic [WORD_W-1:0] fpu_b,
  output logic              fpu_start,
  input  logic              fpu_done,
  input  logic [WORD_W-1:0] fpu_data,
  input  logic [STAT_W-1:0] fpu_status,

  output logic              timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q,      state_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt_q,        gnt_d;
  word_t            op_a_q,       op_a_d;
  word_t            op_b_q,       op_b_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  word_t            res_data_q,   res_data_d;
  status_t          res_stat_q,   res_stat_d;

  logic [1:0]       w_grant;
  logic             w_rsp_ready;

  fpu_rr_arb2 u_rr (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (w_grant)
  );

  assign w_rsp_ready = gnt_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      cnt_q        <= '0;
      res_data_q   <= '0;
      res_stat_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      cnt_q        <= cnt_d;
      res_data_q   <= res_data_d;
      res_stat_q   <= res_stat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    cnt_d        = cnt_q;
    res_data_d   = res_data_q;
    res_stat_d   = res_stat_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    fpu_start    = 1'b0;
    timeout      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The reset qualifier keeps ready low while reset is held, even though the state already reads IDLE.
        if (reset && (w_grant != 2'b00)) begin
          req0_ready   = w_grant[0];
          req1_ready   = w_grant[1];
          gnt_d        = w_grant[1];
          last_grant_d = w_grant[1];
          op_a_d       = w_grant[1] ? req1_a : req0_a;
          op_b_d       = w_grant[1] ? req1_b : req0_b;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        fpu_start = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end

      WAIT: begin
        if (fpu_done) begin
          res_data_d = fpu_data;
          res_stat_d = fpu_status & STAT_MASK;
          state_d    = RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout    = 1'b1;
          res_data_d = '0;
          res_stat_d = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        rsp0_valid = ~gnt_q;
        rsp1_valid = gnt_q;
        if (w_rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign fpu_a       = op_a_q;
  assign fpu_b       = op_b_q;
  assign rsp0_data   = res_data_q;
  assign rsp1_data   = res_data_q;
  assign rsp0_status = res_stat_q;
  assign rsp1_status = res_stat_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// Directed bench for fpu_arbiter: single op, contention, timeout, backpressure,
// reset mid-operation and done/timeout coincidence.
module tb_fpu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [3:0]  rsp0_status, rsp1_status;
  logic [31:0] fpu_a, fpu_b, fpu_data;
  logic        fpu_start, fpu_done, timeout;
  logic [3:0]  fpu_status;

  int n_vec = 0;
  int n_err = 0;
  int tmo_cnt = 0;
  int t0;

  fpu_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_data   (rsp0_data),
    .rsp0_status (rsp0_status),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_data   (rsp1_data),
    .rsp1_status (rsp1_status),
    .fpu_a       (fpu_a),
    .fpu_b       (fpu_b),
    .fpu_start   (fpu_start),
    .fpu_done    (fpu_done),
    .fpu_data    (fpu_data),
    .fpu_status  (fpu_status),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (timeout) tmo_cnt <= tmo_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0; fpu_done = 0;
    reset = 0;
    repeat (2) step();
    reset = 1;
    #1;
  endtask

  // Caller raises the request valid(s); this runs accept -> ISSUE -> WAIT -> RESP -> IDLE.
  task automatic run_op(input int port, input int lat, input logic hold,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input logic [3:0] s);
    #1;
    check("accept_ready", {req1_ready, req0_ready}, (port == 1) ? 2 : 1);
    step();
    if (!hold) begin req0_valid = 0; req1_valid = 0; end
    check("issue_start", fpu_start, 1);
    check("issue_fpu_a", fpu_a, a);
    check("issue_fpu_b", fpu_b, b);
    check("issue_ready", {req1_ready, req0_ready}, 0);
    step();
    check("wait_start", fpu_start, 0);
    repeat (lat - 1) step();
    check("wait_fpu_a_held", fpu_a, a);
    fpu_done = 1; fpu_data = d; fpu_status = s;
    step();
    fpu_done = 0;
    check("resp_valid", {rsp1_valid, rsp0_valid}, (port == 1) ? 2 : 1);
    check("resp_data", (port == 1) ? rsp1_data : rsp0_data, d);
    check("resp_status", (port == 1) ? rsp1_status : rsp0_status, s);
    if (port == 1) rsp1_ready = 1; else rsp0_ready = 1;
    step();
    rsp0_ready = 0; rsp1_ready = 0;
    check("idle_valid", {rsp1_valid, rsp0_valid}, 0);
  endtask

  initial begin
    req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0; fpu_done = 0; fpu_data = 0; fpu_status = 0;
    repeat (2) step();

    // Outputs under reset, with requests pending
    req0_valid = 1; req1_valid = 1;
    #1;
    check("rst_req_ready", {req1_ready, req0_ready}, 0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("rst_fpu_start", fpu_start, 0);
    check("rst_timeout", timeout, 0);
    check("rst_fpu_a", fpu_a, 0);
    check("rst_fpu_b", fpu_b, 0);
    check("rst_rsp0_data", rsp0_data, 0);
    check("rst_rsp1_status", rsp1_status, 0);
    req0_valid = 0; req1_valid = 0;
    reset = 1;
    step();
    check("idle_no_req", {req1_ready, req0_ready}, 0);

    // Single operation on port 0
    req0_valid = 1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
    run_op(0, 3, 1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 4'b0001);

    // Contention, port 0 wins first after reset, then alternation
    apply_reset();
    req0_a = 32'h1111_0000; req0_b = 32'h1111_0001;
    req1_a = 32'h2222_0000; req1_b = 32'h2222_0001;
    req0_valid = 1; req1_valid = 1;
    run_op(0, 2, 1'b1, 32'h1111_0000, 32'h1111_0001, 32'hA000_0000, 4'b0001);
    run_op(1, 2, 1'b1, 32'h2222_0000, 32'h2222_0001, 32'hA000_0001, 4'b1000);
    run_op(0, 2, 1'b1, 32'h1111_0000, 32'h1111_0001, 32'hA000_0002, 4'b0010);
    run_op(1, 2, 1'b0, 32'h2222_0000, 32'h2222_0001, 32'hA000_0003, 4'b0100);

    // Timeout with TIMEOUT_CYCLES = 8
    req1_valid = 1; req1_a = 32'h3333_0000; req1_b = 32'h3333_0001;
    #1;
    check("tmo_accept", req1_ready, 1);
    step();
    req1_valid = 0;
    step();
    t0 = tmo_cnt;
    for (int i = 0; i < 7; i++) begin
      check("tmo_early", timeout, 0);
      step();
    end
    check("tmo_pulse", timeout, 1);
    step();
    check("tmo_after", timeout, 0);
    check("tmo_pulse_count", tmo_cnt - t0, 1);
    check("tmo_rsp_valid", {rsp1_valid, rsp0_valid}, 2);
    check("tmo_rsp_data", rsp1_data, 0);
    check("tmo_rsp_status", rsp1_status, 0);
    step();
    fpu_done = 1; fpu_data = 32'hDEAD_BEEF; fpu_status = 4'b0001;
    step();
    fpu_done = 0;
    check("late_done_data", rsp1_data, 0);
    check("late_done_valid", rsp1_valid, 1);
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;
    fpu_done = 1;
    step();
    fpu_done = 0;
    step();
    check("idle_done_ignored", {fpu_start, rsp1_valid, rsp0_valid}, 0);

    // Backpressure on port 1; port 0 waits and rsp0_ready is ignored
    req1_valid = 1; req1_a = 32'h4444_0000; req1_b = 32'h4444_0001;
    step();
    req1_valid = 0;
    step();
    fpu_done = 1; fpu_data = 32'hC0FF_EE00; fpu_status = 4'b1000;
    step();
    fpu_done = 0;
    req0_valid = 1; rsp0_ready = 1;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp1_valid", rsp1_valid, 1);
      check("bp_rsp1_data", rsp1_data, 32'hC0FF_EE00);
      check("bp_rsp1_status", rsp1_status, 4'b1000);
      check("bp_req0_ready", req0_ready, 0);
      check("bp_rsp0_valid", rsp0_valid, 0);
      step();
    end
    rsp1_ready = 1;
    #1;
    check("bp_release_valid", rsp1_valid, 1);
    step();
    check("bp_idle_valid", rsp1_valid, 0);
    check("bp_idle_req0_ready", req0_ready, 1);
    req0_valid = 0; rsp0_ready = 0; rsp1_ready = 0;

    // Reset while in WAIT
    req0_valid = 1; req0_a = 32'h5555_0000; req0_b = 32'h5555_0001;
    step();
    req0_valid = 0;
    step();
    step();
    check("rw_fpu_a_before", fpu_a, 32'h5555_0000);
    #2;
    reset = 0;
    #1;
    check("rw_fpu_a", fpu_a, 0);
    check("rw_fpu_b", fpu_b, 0);
    check("rw_rsp0_data", rsp0_data, 0);
    check("rw_outputs", {fpu_start, timeout, rsp1_valid, rsp0_valid}, 0);
    step();
    reset = 1;
    fpu_done = 1; fpu_data = 32'h1234_5678; fpu_status = 4'b0001;
    step();
    fpu_done = 0;
    for (int i = 0; i < 3; i++) begin
      check("rw_no_rsp", {fpu_start, rsp1_valid, rsp0_valid}, 0);
      step();
    end
    check("rw_rsp_data", rsp0_data, 0);

    // fpu_done on the final timeout cycle
    t0 = tmo_cnt;
    req0_valid = 1; req0_a = 32'h6666_0000; req0_b = 32'h6666_0001;
    #1;
    check("co_accept", req0_ready, 1);
    step();
    req0_valid = 0;
    step();
    repeat (7) step();
    fpu_done = 1; fpu_data = 32'h3F00_0000; fpu_status = 4'b1000;
    #1;
    check("co_timeout", timeout, 0);
    step();
    fpu_done = 0;
    check("co_valid", {rsp1_valid, rsp0_valid}, 1);
    check("co_data", rsp0_data, 32'h3F00_0000);
    check("co_status", rsp0_status, 4'b1000);
    check("co_no_pulse", tmo_cnt - t0, 0);
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    check("co_idle", rsp0_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
